// File: rtl/stream_arb_mux_pkg.sv
// ============================================================================
// stream_arb_pkg : shared types and helpers for the stream arbiter/mux
// Revision 1.0
// ============================================================================
`default_nettype none

package stream_arb_pkg;

    typedef enum logic {
        ARB_PRIO = 1'b0,
        ARB_RR   = 1'b1
    } arb_mode_e;

    // Modular increment: n-1 wraps back to 0.
    function automatic int unsigned next_idx(input int unsigned idx, input int unsigned n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/stream_arb_mux_if.sv
// ============================================================================
// stream_arb_mux_if : input channels and registered output stream bundle
// Revision 1.0
// ============================================================================
`default_nettype none

interface stream_arb_mux_if #(
    parameter int NUM_CH = 4,
    parameter int DATA_W = 8,
    parameter int IDX_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
);
    logic [NUM_CH-1:0]        in_valid_i;
    logic [NUM_CH*DATA_W-1:0] in_data_i;
    logic [NUM_CH-1:0]        in_ready_o;
    logic                     out_valid_o;
    logic [DATA_W-1:0]        out_data_o;
    logic [IDX_W-1:0]         out_idx_o;
    logic                     out_ready_i;

    // Mux side.
    modport slave (
        input  in_valid_i, in_data_i, out_ready_i,
        output in_ready_o, out_valid_o, out_data_o, out_idx_o
    );

    // Producer/consumer side.
    modport master (
        output in_valid_i, in_data_i, out_ready_i,
        input  in_ready_o, out_valid_o, out_data_o, out_idx_o
    );
endinterface

`default_nettype wire

// File: rtl/stream_arb_mux_rr_arbiter.sv
// ============================================================================
// rr_arbiter : combinational fixed-priority / round-robin grant logic
// Revision 1.0
// ============================================================================
`default_nettype none

module rr_arbiter
    import stream_arb_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int IDX_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  wire logic [NUM_CH-1:0] req_i,
    input  wire logic [IDX_W-1:0]  ptr_i,
    input  wire arb_mode_e         mode_i,
    output logic [NUM_CH-1:0]      gnt_o,
    output logic [IDX_W-1:0]       gnt_idx_o,
    output logic                   any_gnt_o
);

    logic [IDX_W-1:0]    w_eff_ptr;
    logic [NUM_CH-1:0]   w_mask;
    logic [2*NUM_CH-1:0] w_dbl;
    logic [IDX_W:0]      w_first;

    // Upper half is the unmasked request vector, so a search that finds
    // nothing at/after the pointer wraps around to the lowest request.
    always_comb begin
        w_eff_ptr = (mode_i == ARB_RR) ? ptr_i : '0;
        w_mask    = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            w_mask[k] = (IDX_W'(k) >= w_eff_ptr);
        end
        w_dbl   = {req_i, req_i & w_mask};
        w_first = '0;
        for (int i = 2*NUM_CH-1; i >= 0; i--) begin
            if (w_dbl[i]) begin
                w_first = (IDX_W+1)'(i);
            end
        end
    end

    always_comb begin
        if (w_first >= (IDX_W+1)'(NUM_CH)) begin
            gnt_idx_o = IDX_W'(w_first - (IDX_W+1)'(NUM_CH));
        end else begin
            gnt_idx_o = IDX_W'(w_first);
        end
        any_gnt_o = |req_i;
        gnt_o     = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            gnt_o[k] = any_gnt_o && (gnt_idx_o == IDX_W'(k));
        end
    end

endmodule

`default_nettype wire

// File: rtl/stream_arb_mux.sv
// ============================================================================
// stream_arb_mux : N-channel valid/ready arbiter with one registered output slot
// Revision 1.0
// ============================================================================
`default_nettype none

module stream_arb_mux
    import stream_arb_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int DATA_W = 8,
    parameter int IDX_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  wire logic       clk_i,
    input  wire logic       rst_ni,
    input  wire arb_mode_e  mode_i,
    stream_arb_mux_if.slave bus
);

    logic                out_valid_q, out_valid_d;
    logic [DATA_W-1:0]   out_data_q,  out_data_d;
    logic [IDX_W-1:0]    out_idx_q,   out_idx_d;
    logic [IDX_W-1:0]    rr_ptr_q,    rr_ptr_d;

    logic [NUM_CH-1:0]   w_gnt;
    logic [IDX_W-1:0]    w_gnt_idx;
    logic                w_any_gnt;
    logic                w_can_load;
    logic                w_xfer;
    logic [DATA_W-1:0]   w_mux;

    rr_arbiter #(
        .NUM_CH (NUM_CH),
        .IDX_W  (IDX_W)
    ) u_arb (
        .req_i     (bus.in_valid_i),
        .ptr_i     (rr_ptr_q),
        .mode_i    (mode_i),
        .gnt_o     (w_gnt),
        .gnt_idx_o (w_gnt_idx),
        .any_gnt_o (w_any_gnt)
    );

    assign w_can_load     = !out_valid_q || bus.out_ready_i;
    assign w_xfer         = w_any_gnt && w_can_load;
    assign bus.in_ready_o = w_gnt & {NUM_CH{w_can_load}};

    always_comb begin
        w_mux = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            w_mux = w_mux | (bus.in_data_i[k*DATA_W +: DATA_W] & {DATA_W{w_gnt[k]}});
        end
    end

    // Pointer advances on every transfer in either mode so a later switch
    // to round-robin resumes after the last winner.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_idx_d   = out_idx_q;
        rr_ptr_d    = rr_ptr_q;
        if (w_xfer) begin
            out_valid_d = 1'b1;
            out_data_d  = w_mux;
            out_idx_d   = w_gnt_idx;
            rr_ptr_d    = IDX_W'(next_idx(32'(w_gnt_idx), NUM_CH));
        end else if (bus.out_ready_i) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_idx_q   <= '0;
            rr_ptr_q    <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_idx_q   <= out_idx_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    assign bus.out_valid_o = out_valid_q;
    assign bus.out_data_o  = out_data_q;
    assign bus.out_idx_o   = out_idx_q;

endmodule

`default_nettype wire
